// File: rtl/sistema_gpio_pio.sv
// sistema_gpio_pio: Avalon-MM GPIO port (zero-wait-state slave).
// Per-bit direction, atomic set/clear/toggle of the output register, two-flop input
// synchroniser, sticky edge capture with write-1-to-clear, and a maskable level IRQ.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   address_i    register word address (0 DATA, 1 DIR, 2 IRQ_MASK, 3 EDGE_CAP,
//                4 OUTSET, 5 OUTCLR, 6 OUTTGL, 7 reserved)
//   chipselect_i slave select
//   write_n_i    active-low write strobe
//   writedata_i  write data, bits above WIDTH ignored
//   readdata_o   combinational read data, bits above WIDTH read 0
//   in_port_i    asynchronous pin inputs
//   out_port_o   output data register
//   oe_o         per-bit output enable (direction register, 1 = output)
//   irq_o        level interrupt, |(edge_cap & mask)
module sistema_gpio_pio #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    parameter logic [WIDTH-1:0] RESET_DIR = '1,
    parameter int unsigned      EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address_i,
    input  logic             chipselect_i,
    input  logic             write_n_i,
    input  logic [31:0]      writedata_i,
    output logic [31:0]      readdata_o,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] out_port_o,
    output logic [WIDTH-1:0] oe_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [1:0]       arm_q, arm_d;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rise, fall, edge_sel;
    logic             armed;
    logic [WIDTH-1:0] rd_w;

    // Upper writedata bits are intentionally ignored when WIDTH < 32.
    logic unused_wd;
    assign unused_wd = ^writedata_i;

    assign wr_en = chipselect_i && !write_n_i;
    assign wd    = writedata_i[WIDTH-1:0];

    // Register writes and atomic output updates
    always_comb begin
        data_d  = data_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr_en) begin
            case (address_i)
                3'd0:    data_d  = wd;
                3'd1:    dir_d   = wd;
                3'd2:    mask_d  = wd;
                3'd3:    cap_clr = wd;
                3'd4:    data_d  = data_q | wd;
                3'd5:    data_d  = data_q & ~wd;
                3'd6:    data_d  = data_q ^ wd;
                default: ;
            endcase
        end
    end

    // Edge detect on the synchronised pin vs. its one-cycle-delayed copy
    assign rise  = sync2_q & ~prev_q;
    assign fall  = ~sync2_q & prev_q;
    assign armed = (arm_q == 2'd3);

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_sel = rise;
            1:       edge_sel = fall;
            default: edge_sel = rise | fall;
        endcase
    end

    // A new edge beats a simultaneous write-1-to-clear on the same bit.
    always_comb begin
        cap_d = (cap_q & ~cap_clr) | (armed ? edge_sel : '0);
    end

    // Arming counter saturates at 3; keeps pins already high at reset release
    // from being seen as edges while the synchroniser fills.
    always_comb begin
        arm_d = armed ? arm_q : arm_q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_OUT;
            dir_q   <= RESET_DIR;
            mask_q  <= '0;
            cap_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            arm_q   <= 2'd0;
        end else begin
            data_q  <= data_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            sync1_q <= in_port_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            arm_q   <= arm_d;
        end
    end

    // Read mux, side-effect free
    always_comb begin
        rd_w = '0;
        case (address_i)
            3'd0:    rd_w = (dir_q & data_q) | (~dir_q & sync2_q);
            3'd1:    rd_w = dir_q;
            3'd2:    rd_w = mask_q;
            3'd3:    rd_w = cap_q;
            default: rd_w = '0;
        endcase
    end

    assign readdata_o = 32'(rd_w);
    assign out_port_o = data_q;
    assign oe_o       = dir_q;
    assign irq_o      = |(cap_q & mask_q);

endmodule

// File: tb/tb_sistema_gpio_pio.sv
// Self-checking bench for sistema_gpio_pio (WIDTH=8, default parameters).
// A reference model tracks register contents and the history of sampled pin values;
// edges are derived from that history rather than from flop-level state.
module tb_sistema_gpio_pio;

    localparam int unsigned EDGE_TYPE = 0;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address_i;
    logic        chipselect_i;
    logic        write_n_i;
    logic [31:0] writedata_i;
    logic [31:0] readdata_o;
    logic [7:0]  in_port_i;
    logic [7:0]  out_port_o;
    logic [7:0]  oe_o;
    logic        irq_o;

    sistema_gpio_pio #(
        .WIDTH     (8),
        .RESET_OUT (8'h00),
        .RESET_DIR (8'hFF),
        .EDGE_TYPE (EDGE_TYPE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address_i    (address_i),
        .chipselect_i (chipselect_i),
        .write_n_i    (write_n_i),
        .writedata_i  (writedata_i),
        .readdata_o   (readdata_o),
        .in_port_i    (in_port_i),
        .out_port_o   (out_port_o),
        .oe_o         (oe_o),
        .irq_o        (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [7:0] m_out, m_dir, m_mask, m_cap;
    logic [7:0] pins[$];  // pin value sampled at each clock edge since reset release

    function automatic logic [7:0] samp(input int idx);
        if (idx < 0) return 8'h00;
        return pins[idx];
    endfunction

    task automatic model_reset();
        m_out  = 8'h00;
        m_dir  = 8'hFF;
        m_mask = 8'h00;
        m_cap  = 8'h00;
        pins.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [7:0] insync;
        insync = samp(pins.size() - 2);
        case (a)
            3'd0:    return {24'h0, (m_dir & m_out) | (~m_dir & insync)};
            3'd1:    return {24'h0, m_dir};
            3'd2:    return {24'h0, m_mask};
            3'd3:    return {24'h0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic [2:0] a, input logic cs, input logic wn,
                              input logic [31:0] wd, input logic [7:0] pin);
        int n;
        logic [7:0] cur, old, ed, w, clr;
        n   = pins.size();
        // Edge visible at this clock: pin from two edges ago vs. three edges ago
        cur = samp(n - 2);
        old = samp(n - 3);
        if (EDGE_TYPE == 0)      ed = cur & ~old;
        else if (EDGE_TYPE == 1) ed = ~cur & old;
        else                     ed = cur ^ old;
        if (n < 3) ed = 8'h00;
        w   = wd[7:0];
        clr = 8'h00;
        if (cs && !wn) begin
            case (a)
                3'd0: m_out  = w;
                3'd1: m_dir  = w;
                3'd2: m_mask = w;
                3'd3: clr    = w;
                3'd4: m_out  = m_out | w;
                3'd5: m_out  = m_out & ~w;
                3'd6: m_out  = m_out ^ w;
                default: ;
            endcase
        end
        m_cap = (m_cap & ~clr) | ed;
        pins.push_back(pin);
    endtask

    // One bus cycle: drive at negedge, check read, clock, check outputs
    task automatic drive(input logic [2:0] a, input logic cs, input logic wn,
                         input logic [31:0] wd, input logic [7:0] pin);
        @(negedge clk);
        address_i    = a;
        chipselect_i = cs;
        write_n_i    = wn;
        writedata_i  = wd;
        in_port_i    = pin;
        #1;
        check("readdata", readdata_o, model_read(a));
        @(posedge clk);
        model_edge(a, cs, wn, wd, pin);
        #1;
        check("out_port", {24'h0, out_port_o}, {24'h0, m_out});
        check("oe", {24'h0, oe_o}, {24'h0, m_dir});
        check("irq", {31'h0, irq_o}, {31'h0, |(m_cap & m_mask)});
        chipselect_i = 1'b0;
        write_n_i    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [7:0] pin);
        drive(a, 1'b1, 1'b0, wd, pin);
    endtask

    task automatic idle(input logic [7:0] pin);
        drive(3'd7, 1'b0, 1'b1, 32'h0, pin);
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] v);
        address_i = a;
        #1;
        v = readdata_o;
    endtask

    task automatic async_reset_pulse();
        // Called just after a rising edge; pulse stays well inside one cycle
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_out_port", {24'h0, out_port_o}, 32'h00);
        check("rst_oe", {24'h0, oe_o}, 32'hFF);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        #1;
        reset_n = 1'b1;
    endtask

    logic [31:0] v;

    initial begin
        reset_n      = 1'b0;
        address_i    = 3'd0;
        chipselect_i = 1'b0;
        write_n_i    = 1'b1;
        writedata_i  = 32'h0;
        in_port_i    = 8'hFF;
        model_reset();

        // T1 reset with pins high
        repeat (3) @(posedge clk);
        #1;
        check("t1_out_port", {24'h0, out_port_o}, 32'h00);
        check("t1_oe", {24'h0, oe_o}, 32'hFF);
        check("t1_irq", {31'h0, irq_o}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) idle(8'hFF);
        peek(3'd3, v);
        check("t1_edge_cap", v, 32'h0);
        repeat (2) idle(8'hFF);

        // T2 atomic ops
        wr(3'd0, 32'h0000_000F, 8'hFF);
        check("t2_data", {24'h0, out_port_o}, 32'h0F);
        wr(3'd4, 32'hFFFF_FF30 & 32'h0000_0030, 8'hFF);
        check("t2_set", {24'h0, out_port_o}, 32'h3F);
        wr(3'd5, 32'h0000_0003, 8'hFF);
        check("t2_clr", {24'h0, out_port_o}, 32'h3C);
        wr(3'd6, 32'h0000_0081, 8'hFF);
        check("t2_tgl", {24'h0, out_port_o}, 32'hBD);

        // T3 direction mux
        wr(3'd1, 32'h0000_00F0, 8'h55);
        wr(3'd0, 32'hABCD_00AA, 8'h55);
        repeat (2) idle(8'h55);
        peek(3'd0, v);
        check("t3_data_rd", v, 32'hA5);
        check("t3_oe", {24'h0, oe_o}, 32'hF0);

        // T4 edge capture and IRQ on bit 0
        wr(3'd2, 32'h0000_0001, 8'h54);
        repeat (3) idle(8'h54);
        idle(8'h55);                 // edge k samples the rise
        peek(3'd3, v);
        check("t4_cap_k", v, 32'h0);
        idle(8'h55);                 // edge k+1
        peek(3'd3, v);
        check("t4_cap_k1", v, 32'h0);
        idle(8'h55);                 // edge k+2
        peek(3'd3, v);
        check("t4_cap_k2", v, 32'h01);
        check("t4_irq", {31'h0, irq_o}, 32'h1);
        wr(3'd3, 32'h0000_0001, 8'h55);
        peek(3'd3, v);
        check("t4_cap_clr", v, 32'h0);
        check("t4_irq_clr", {31'h0, irq_o}, 32'h0);

        // T5 clear coinciding with a new capture
        repeat (3) idle(8'h54);
        idle(8'h55);                 // edge k
        idle(8'h55);                 // edge k+1
        wr(3'd3, 32'h0000_0001, 8'h55);  // edge k+2: clear vs set
        peek(3'd3, v);
        check("t5_collision", v, 32'h01);

        // T6 mid-operation reset
        wr(3'd0, 32'h0000_005A, 8'h55);
        check("t6_pre_irq", {31'h0, irq_o}, 32'h1);
        check("t6_pre_out", {24'h0, out_port_o}, 32'h5A);
        async_reset_pulse();
        repeat (5) idle(8'hFF);
        peek(3'd3, v);
        check("t6_no_cap", v, 32'h0);

        // Randomised traffic
        wr(3'd2, 32'h0000_00FF, 8'hFF);
        for (int i = 0; i < 600; i++) begin
            logic [7:0] pin;
            pin = in_port_i;
            if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
            drive(3'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                  $urandom, pin);
            if (i == 300) async_reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
